// File: rtl/eth_tx_scheduler.sv
// eth_tx_scheduler: packet-atomic arbiter merging NUM_PORTS AXIS sources into one framer TX stream.
// Default is round-robin; define ETH_TX_SCHED_STRICT_PRIO_EN for fixed priority (port 0 highest).
module eth_tx_scheduler #(
    parameter int AXIS_BYTES = 4,
    parameter int NUM_PORTS  = 2
) (
    input  logic                              clk,
    input  logic                              sresetn,
    input  logic [NUM_PORTS-1:0]              axis_i_tvalid,
    output logic [NUM_PORTS-1:0]              axis_i_tready,
    input  logic [NUM_PORTS-1:0]              axis_i_tlast,
    input  logic [NUM_PORTS*AXIS_BYTES-1:0]   axis_i_tkeep,
    input  logic [NUM_PORTS*AXIS_BYTES*8-1:0] axis_i_tdata,
    input  logic [NUM_PORTS*48-1:0]           axis_i_dst_mac,
    input  logic [NUM_PORTS*16-1:0]           axis_i_ethertype,
    output logic                              axis_o_tvalid,
    input  logic                              axis_o_tready,
    output logic                              axis_o_tlast,
    output logic [AXIS_BYTES-1:0]             axis_o_tkeep,
    output logic [AXIS_BYTES*8-1:0]           axis_o_tdata,
    output logic [47:0]                       axis_o_dst_mac,
    output logic [15:0]                       axis_o_ethertype,
    output logic [$clog2(NUM_PORTS)-1:0]      grant_o
);
    localparam int GW = $clog2(NUM_PORTS);
    localparam int DW = AXIS_BYTES * 8;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PASS = 1'b1;

    logic [0:0]    r_state;
    logic [GW-1:0] r_grant;
    logic [47:0]   r_dst_mac;
    logic [15:0]   r_ethertype;
    logic [GW-1:0] w_winner;
    logic          w_pass;

`ifdef ETH_TX_SCHED_STRICT_PRIO_EN
    always_comb begin
        w_winner = r_grant;
        for (int i = NUM_PORTS - 1; i >= 0; i--)
            if (axis_i_tvalid[GW'(i)]) w_winner = GW'(i);
    end
`else
    logic [GW-1:0] w_cand;
    // Scan downward so the port closest after the last grant is written last and wins.
    always_comb begin
        w_winner = r_grant;
        w_cand   = r_grant;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            w_cand = GW'((int'(r_grant) + i) % NUM_PORTS);
            if (axis_i_tvalid[w_cand]) w_winner = w_cand;
        end
    end
`endif

    assign w_pass           = r_state == PASS;
    assign axis_o_tvalid    = w_pass & axis_i_tvalid[r_grant];
    assign axis_o_tlast     = axis_i_tlast[r_grant];
    assign axis_o_tkeep     = axis_i_tkeep[r_grant*AXIS_BYTES +: AXIS_BYTES];
    assign axis_o_tdata     = axis_i_tdata[r_grant*DW +: DW];
    assign axis_i_tready    = w_pass ? {{(NUM_PORTS-1){1'b0}}, axis_o_tready} << r_grant : '0;
    assign axis_o_dst_mac   = r_dst_mac;
    assign axis_o_ethertype = r_ethertype;
    assign grant_o          = r_grant;

    always_ff @(posedge clk) begin
        if (!sresetn) begin
            r_state     <= IDLE;
            r_grant     <= GW'(NUM_PORTS - 1);
            r_dst_mac   <= '0;
            r_ethertype <= '0;
        end else if (r_state == IDLE) begin
            if (|axis_i_tvalid) begin
                r_state     <= PASS;
                r_grant     <= w_winner;
                r_dst_mac   <= axis_i_dst_mac[w_winner*48 +: 48];
                r_ethertype <= axis_i_ethertype[w_winner*16 +: 16];
            end
        end else if (axis_o_tvalid & axis_o_tready & axis_o_tlast) begin
            r_state <= IDLE;
        end
    end
endmodule
